cc_mem_read_responder: RTL and testbench

- Memory-side transmitter of the AXI-style read path that feeds the cache controller's data fill unit.
- Accepts AR requests, queues them, and reads 64-bit words from a synchronous backing store after a fixed access latency.
- Returns each burst on the R channel as rdata/rvalid/rlast beats. There is no rready: the receiver must accept every beat.

---
 rtl/cc_pkg.sv | 28 ++
 rtl/cc_ar_fifo.sv | 59 +++++
 rtl/cc_mem_read_responder.sv | 136 +++++++++++++
 tb/tb_cc_mem_read_responder.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// Shared types and constants for the cache-controller memory read responder.
package cc_pkg;

  localparam int CC_DATA_W     = 64;
  localparam int CC_LINE_BEATS = 8;
  localparam int CC_LINE_BYTES = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } cc_state_e;

  typedef struct packed {
    logic [28:0] addr;
    logic [3:0]  len;
  } ar_req_t;

  // Next word address of a burst: INCR rolls over the whole 29-bit space,
  // WRAP only advances the word index inside the current 64B line.
  function automatic logic [28:0] cc_next_addr(input logic [28:0] addr, input logic wrap);
    if (wrap) begin
      return {addr[28:3], addr[2:0] + 3'd1};
    end
    return addr + 29'd1;
  endfunction

endpackage

// File: rtl/cc_ar_fifo.sv
// Small synchronous FIFO holding queued AR requests; pushes while full and
// pops while empty are ignored.
module cc_ar_fifo
  import cc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  ar_req_t                  din_i,
  input  logic                     pop_i,
  output ar_req_t                  dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  ar_req_t        mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [PW:0]    count_q;
  logic           do_push;
  logic           do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop keeps count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cc_mem_read_responder.sv
// Memory-side AXI-style read responder: queues AR requests, waits a fixed
// access latency, reads the backing store one word per cycle and returns the
// burst on the R channel (no rready, every beat must be taken).
// Optional macro CC_CRITICAL_WORD_FIRST_EN turns 8-beat bursts into
// line-wrapping (critical word first) bursts.
module cc_mem_read_responder
  import cc_pkg::*;
#(
  parameter int AR_FIFO_DEPTH = 4,
  parameter int LATENCY       = 4,
  parameter int BK_AW         = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arvalid_i,
  input  logic [31:0]           araddr_i,
  input  logic [3:0]            arlen_i,
  output logic                  arready_o,
  output logic                  rvalid_o,
  output logic [CC_DATA_W-1:0]  rdata_o,
  output logic                  rlast_o,
  output logic                  bk_ren_o,
  output logic [BK_AW-1:0]      bk_raddr_o,
  input  logic [CC_DATA_W-1:0]  bk_rdata_i
);

  localparam int CW  = $clog2(AR_FIFO_DEPTH) + 1;
  localparam int WCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  cc_state_e        state_q;
  logic [28:0]      cur_addr_q;
  logic [28:0]      cur_addr_d;
  logic [3:0]       beats_left_q;
  logic [WCW-1:0]   wait_cnt_q;
  logic             wrap_q;
  logic             wrap_d;
  logic             rvalid_q;
  logic             rlast_q;

  ar_req_t          push_req;
  ar_req_t          head_req;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^araddr_i[2:0];

  assign push_req  = '{addr: araddr_i[31:3], len: arlen_i};
  assign arready_o = (fifo_count != CW'(AR_FIFO_DEPTH));
  assign fifo_push = arvalid_i && !fifo_full;
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

  cc_ar_fifo #(
    .DEPTH (AR_FIFO_DEPTH)
  ) u_ar_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .din_i   (push_req),
    .pop_i   (fifo_pop),
    .dout_o  (head_req),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef CC_CRITICAL_WORD_FIRST_EN
  assign wrap_d = (head_req.len == 4'd7);
`else
  assign wrap_d = 1'b0;
`endif

  assign cur_addr_d = cc_next_addr(cur_addr_q, wrap_q);

  assign bk_ren_o   = (state_q == BURST);
  assign bk_raddr_o = bk_ren_o ? cur_addr_q[BK_AW-1:0] : '0;

  assign rvalid_o = rvalid_q;
  assign rlast_o  = rlast_q;
  assign rdata_o  = rvalid_q ? bk_rdata_i : '0;

  // Burst sequencer: pop a request, sit out the access latency, then issue one
  // backing-store read per cycle until the beat count is exhausted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      wait_cnt_q   <= '0;
      wrap_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            cur_addr_q   <= head_req.addr;
            beats_left_q <= head_req.len;
            wait_cnt_q   <= WCW'(LATENCY - 1);
            wrap_q       <= wrap_d;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt_q == '0) begin
            state_q <= BURST;
          end else begin
            wait_cnt_q <= wait_cnt_q - WCW'(1);
          end
        end
        BURST: begin
          cur_addr_q <= cur_addr_d;
          if (beats_left_q == 4'd0) begin
            state_q <= IDLE;
          end else begin
            beats_left_q <= beats_left_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // R strobes trail the backing read by one cycle, matching the store latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      rvalid_q <= bk_ren_o;
      rlast_q  <= bk_ren_o && (beats_left_q == 4'd0);
    end
  end

endmodule

// File: tb/tb_cc_mem_read_responder.sv
// Self-checking bench for cc_mem_read_responder. A queue-based timing model
// predicts every output each cycle; directed scenarios add literal checks.
// Honours CC_CRITICAL_WORD_FIRST_EN the same way as the design.
module tb_cc_mem_read_responder;
  import cc_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 4;
  localparam int BKAW  = 26;
  localparam int MAXC  = 4096;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arvalid_i = 1'b0;
  logic [31:0]       araddr_i = '0;
  logic [3:0]        arlen_i = '0;
  logic              arready_o;
  logic              rvalid_o;
  logic [63:0]       rdata_o;
  logic              rlast_o;
  logic              bk_ren_o;
  logic [BKAW-1:0]   bk_raddr_o;
  logic [63:0]       bk_rdata_i = '0;

  always #5 clk = ~clk;

  cc_mem_read_responder #(
    .AR_FIFO_DEPTH (DEPTH),
    .LATENCY       (LAT),
    .BK_AW         (BKAW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arvalid_i  (arvalid_i),
    .araddr_i   (araddr_i),
    .arlen_i    (arlen_i),
    .arready_o  (arready_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .rlast_o    (rlast_o),
    .bk_ren_o   (bk_ren_o),
    .bk_raddr_o (bk_raddr_o),
    .bk_rdata_i (bk_rdata_i)
  );

  int        total = 0;
  int        bad = 0;
  int        cyc = 0;
  int        freeAt = 0;
  bit        identityMem = 1'b1;
  ar_req_t   q[$];

  logic            expRen   [MAXC];
  logic [BKAW-1:0] expRaddr [MAXC];
  logic            expValid [MAXC];
  logic            expLast  [MAXC];
  logic [63:0]     expData  [MAXC];

  // Backing-store contents as a pure function of the word address.
  function automatic logic [63:0] memWord(input logic [BKAW-1:0] a);
    if (identityMem) return {38'h0, a};
    return {6'h15, ~a, 6'h2A, a};
  endfunction

  // Synchronous backing store: data the cycle after the read enable.
  always @(posedge clk) bk_rdata_i <= bk_ren_o ? memWord(bk_raddr_o) : 64'h0;

  function automatic logic [93:0] observe();
    return {arready_o, rvalid_o, rlast_o, bk_ren_o,
            bk_ren_o ? bk_raddr_o : {BKAW{1'b0}},
            rvalid_o ? rdata_o : 64'h0};
  endfunction

  function automatic logic [93:0] expNow();
    return {(q.size() != DEPTH), expValid[cyc], expLast[cyc], expRen[cyc],
            expRen[cyc] ? expRaddr[cyc] : {BKAW{1'b0}},
            expValid[cyc] ? expData[cyc] : 64'h0};
  endfunction

  task automatic clearModel();
    q.delete();
    freeAt = 0;
    for (int c = cyc; c < MAXC; c++) begin
      expRen[c] = 1'b0; expRaddr[c] = '0; expValid[c] = 1'b0;
      expLast[c] = 1'b0; expData[c] = '0;
    end
  endtask

  // Reference model step for the current cycle, then drive the AR inputs.
  task automatic modelStep(input logic v, input logic [31:0] a, input logic [3:0] l);
    logic        acc;
    logic        wrapB;
    ar_req_t     h;
    logic [28:0] wa;
    int          r;
    acc = v && (q.size() != DEPTH);
    if (cyc >= freeAt && q.size() > 0) begin
      h = q.pop_front();
      wrapB = 1'b0;
`ifdef CC_CRITICAL_WORD_FIRST_EN
      wrapB = (h.len == 4'd7);
`endif
      for (int k = 0; k <= int'(h.len); k++) begin
        wa = wrapB ? {h.addr[28:3], h.addr[2:0] + 3'(k)} : h.addr + 29'(k);
        r = cyc + LAT + 1 + k;
        if (r + 1 < MAXC) begin
          expRen[r]     = 1'b1;
          expRaddr[r]   = wa[BKAW-1:0];
          expValid[r+1] = 1'b1;
          expLast[r+1]  = (k == int'(h.len));
          expData[r+1]  = memWord(wa[BKAW-1:0]);
        end
      end
      freeAt = cyc + LAT + int'(h.len) + 2;
    end
    if (acc) q.push_back('{addr: a[31:3], len: l});
    arvalid_i = v;
    araddr_i  = a;
    arlen_i   = l;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (observe() !== expNow()) begin
        bad++;
        $display("[TB] FAIL reset cyc=%0d got=%h want=%h", cyc, observe(), expNow());
      end
      if (i == 3) rst_n = 1'b1;
      modelStep(1'b0, 32'h0, 4'h0);
      @(posedge clk); cyc++;
    end
  endtask

  task automatic test_single_burst();
    int t0, firstV, lastV;
    logic [63:0] got[$];
    identityMem = 1'b1;
    firstV = -1; lastV = -1; t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (observe() !== expNow()) begin
        bad++;
        $display("[TB] FAIL burst cyc=%0d got=%h want=%h", cyc, observe(), expNow());
      end
      if (rvalid_o) begin
        if (firstV < 0) firstV = cyc;
        got.push_back(rdata_o);
      end
      if (rvalid_o && rlast_o) lastV = cyc;
      modelStep(i == 0, 32'h1000, 4'd7);
      @(posedge clk); cyc++;
    end
    total++;
    if (firstV != t0 + 7 || lastV != t0 + 14 || got.size() != 8) begin
      bad++;
      $display("[TB] FAIL burst_timing got first=%0d last=%0d n=%0d want first=%0d last=%0d n=8",
               firstV, lastV, got.size(), t0 + 7, t0 + 14);
    end
    for (int j = 0; j < got.size() && j < 8; j++) begin
      total++;
      if (got[j] !== 64'h200 + 64'(j)) begin
        bad++;
        $display("[TB] FAIL burst_data beat=%0d got=%h want=%h", j, got[j], 64'h200 + 64'(j));
      end
    end
  endtask

  task automatic test_single_beat();
    int n;
    logic [63:0] d;
    logic lastSame;
    identityMem = 1'b1;
    n = 0; d = '0; lastSame = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (observe() !== expNow()) begin
        bad++;
        $display("[TB] FAIL beat cyc=%0d got=%h want=%h", cyc, observe(), expNow());
      end
      if (rvalid_o) begin n++; d = rdata_o; lastSame = rlast_o; end
      modelStep(i == 0, 32'h8, 4'd0);
      @(posedge clk); cyc++;
    end
    total++;
    if (n != 1 || d !== 64'h1 || lastSame !== 1'b1) begin
      bad++;
      $display("[TB] FAIL single_beat got n=%0d data=%h last=%b want n=1 data=1 last=1", n, d, lastSame);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] got[$];
    logic [63:0] want;
    identityMem = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (observe() !== expNow()) begin
        bad++;
        $display("[TB] FAIL wrap cyc=%0d got=%h want=%h", cyc, observe(), expNow());
      end
      if (rvalid_o) got.push_back(rdata_o);
      modelStep(i == 0, 32'h1038, 4'd7);
      @(posedge clk); cyc++;
    end
    for (int j = 0; j < 8; j++) begin
`ifdef CC_CRITICAL_WORD_FIRST_EN
      want = 64'h200 + 64'((7 + j) % 8);
`else
      want = 64'h207 + 64'(j);
`endif
      total++;
      if (j >= got.size() || got[j] !== want) begin
        bad++;
        $display("[TB] FAIL wrap_data beat=%0d got=%h want=%h", j, (j < got.size()) ? got[j] : 64'hx, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int firsts[$];
    int lasts[$];
    logic inBurst, rdy5;
    identityMem = 1'b0;
    inBurst = 1'b0; rdy5 = 1'bx; t0 = cyc;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      total++;
      if (observe() !== expNow()) begin
        bad++;
        $display("[TB] FAIL b2b cyc=%0d got=%h want=%h", cyc, observe(), expNow());
      end
      if (i == 5) rdy5 = arready_o;
      if (rvalid_o && !inBurst) begin firsts.push_back(cyc); inBurst = 1'b1; end
      if (rvalid_o && rlast_o) begin lasts.push_back(cyc); inBurst = 1'b0; end
      modelStep(i < 6, 32'h0004_0000 + 32'(i * 64), 4'($urandom_range(0, 3)));
      @(posedge clk); cyc++;
    end
    total++;
    if (rdy5 !== 1'b0 || lasts.size() != 5 || firsts.size() != 5) begin
      bad++;
      $display("[TB] FAIL b2b_accept got arready@6th=%b bursts=%0d want arready@6th=0 bursts=5", rdy5, lasts.size());
    end
    total++;
    if (firsts.size() == 0 || firsts[0] != t0 + 7) begin
      bad++;
      $display("[TB] FAIL b2b_first got=%0d want=%0d", (firsts.size() > 0) ? firsts[0] : -1, t0 + 7);
    end
    for (int j = 0; j + 1 < firsts.size() && j < lasts.size(); j++) begin
      total++;
      if (firsts[j+1] - lasts[j] != LAT + 2) begin
        bad++;
        $display("[TB] FAIL b2b_gap idx=%0d got=%0d want=%0d", j, firsts[j+1] - lasts[j], LAT + 2);
      end
    end
  endtask

  task automatic test_addr_wrap();
    logic [BKAW-1:0] seen[$];
    identityMem = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      total++;
      if (observe() !== expNow()) begin
        bad++;
        $display("[TB] FAIL topwrap cyc=%0d got=%h want=%h", cyc, observe(), expNow());
      end
      if (bk_ren_o) seen.push_back(bk_raddr_o);
      modelStep(i == 0, 32'hFFFF_FFF8, 4'd1);
      @(posedge clk); cyc++;
    end
    total++;
    if (seen.size() != 2 || seen[0] !== {BKAW{1'b1}} || seen[1] !== {BKAW{1'b0}}) begin
      bad++;
      $display("[TB] FAIL topwrap_addr got n=%0d a0=%h a1=%h want n=2 a0=%h a1=0", seen.size(),
               (seen.size() > 0) ? seen[0] : {BKAW{1'bx}}, (seen.size() > 1) ? seen[1] : {BKAW{1'bx}}, {BKAW{1'b1}});
    end
  endtask

  task automatic test_reset_mid_burst();
    int pre, resetI;
    logic [63:0] post[$];
    identityMem = 1'b1;
    pre = 0; resetI = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (observe() !== expNow()) begin
        bad++;
        $display("[TB] FAIL rstmid cyc=%0d got=%h want=%h", cyc, observe(), expNow());
      end
      if (rvalid_o && resetI < 0) pre++;
      if (rvalid_o && resetI >= 0) post.push_back(rdata_o);
      if (resetI < 0 && pre == 3) begin
        resetI = i;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (rvalid_o !== 1'b0 || bk_ren_o !== 1'b0 || arready_o !== 1'b1) begin
          bad++;
          $display("[TB] FAIL rstmid_now got rvalid=%b ren=%b arready=%b want 0 0 1", rvalid_o, bk_ren_o, arready_o);
        end
        clearModel();
      end
      if (resetI >= 0 && i == resetI + 3) rst_n = 1'b1;
      modelStep(i == 0 || (resetI >= 0 && i == resetI + 4),
                (resetI >= 0) ? 32'h3000 : 32'h2000, (resetI >= 0) ? 4'd3 : 4'd7);
      @(posedge clk); cyc++;
    end
    total++;
    if (resetI < 0 || post.size() != 4) begin
      bad++;
      $display("[TB] FAIL rstmid_after got beats=%0d want 4", post.size());
    end
    for (int j = 0; j < post.size() && j < 4; j++) begin
      total++;
      if (post[j] !== 64'h600 + 64'(j)) begin
        bad++;
        $display("[TB] FAIL rstmid_data beat=%0d got=%h want=%h", j, post[j], 64'h600 + 64'(j));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    identityMem = 1'b0;
    for (int i = 0; i < 650; i++) begin
      @(negedge clk);
      total++;
      if (observe() !== expNow()) begin
        bad++;
        $display("[TB] FAIL random cyc=%0d got=%h want=%h", cyc, observe(), expNow());
      end
      a = $urandom();
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFC0 | a[5:0];
      modelStep((i < 500) && ($urandom_range(0, 2) == 0), a, 4'($urandom_range(0, 15)));
      @(posedge clk); cyc++;
    end
  endtask

  // Scenario sequence and the single summary line.
  initial begin
    clearModel();
    test_reset();
    test_single_burst();
    test_single_beat();
    test_wrap();
    test_back_to_back();
    test_addr_wrap();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
